// File: rtl/nes_clkgen.sv
// NTSC/PAL clock-enable and reset sequencer for the NES core. All outputs are
// registered strobes/levels on clk_ppu8; consumers qualify their logic with them.
module nes_clkgen #(
  parameter int NTSC_PPU_DIV = 8,
  parameter int NTSC_CPU_DIV = 24,
  parameter int NTSC_M2_RISE = 16,
  parameter int PAL_PPU_DIV  = 10,
  parameter int PAL_CPU_DIV  = 32,
  parameter int PAL_M2_RISE  = 20,
  parameter int RST_PPU_DLY  = 15,
  parameter int RST_CPU_DLY  = 6
) (
  input  logic clk_ppu8,
  input  logic rst,
  input  logic pal_mode,
  input  logic cpu_halt,
  input  logic cpu_step,
  output logic ppu_ce,
  output logic cpu_ce,
  output logic m2,
  output logic rst_ppu,
  output logic rst_cpu,
  output logic pal_active
);
  localparam int CW = 8;

  logic [CW-1:0] pcnt, mcnt;
  logic [CW-1:0] pdiv, mdiv, m2r;
  logic [CW-1:0] rcnt_ppu, rcnt_cpu;
  logic          pwrap, mwrap;
  logic          halted, step_pend, suppress;

  always_comb begin
    pdiv     = pal_active ? CW'(PAL_PPU_DIV) : CW'(NTSC_PPU_DIV);
    mdiv     = pal_active ? CW'(PAL_CPU_DIV) : CW'(NTSC_CPU_DIV);
    m2r      = pal_active ? CW'(PAL_M2_RISE) : CW'(NTSC_M2_RISE);
    pwrap    = (pcnt == pdiv - CW'(1));
    mwrap    = (mcnt == mdiv - CW'(1));
    suppress = halted && !step_pend;
  end

  always_ff @(posedge clk_ppu8) begin
    if (rst) begin
      pcnt       <= '0;
      mcnt       <= '0;
      pal_active <= pal_mode;
      halted     <= 1'b0;
      step_pend  <= 1'b0;
      ppu_ce     <= 1'b0;
      cpu_ce     <= 1'b0;
      m2         <= 1'b0;
      rcnt_ppu   <= CW'(RST_PPU_DLY);
      rcnt_cpu   <= CW'(RST_CPU_DLY);
      rst_ppu    <= 1'b1;
      rst_cpu    <= 1'b1;
    end else begin
      pcnt <= pwrap ? '0 : pcnt + CW'(1);
      mcnt <= mwrap ? '0 : mcnt + CW'(1);
      // Mode only changes on the joint wrap, so both counters restart at 0
      // under the new divisors; sampling pal_mode here also cancels a toggle-back.
      if (pwrap && mwrap)
        pal_active <= pal_mode;

      halted <= cpu_halt;
      if (mcnt == '0 && step_pend)
        step_pend <= 1'b0;
      else if (cpu_step && halted)
        step_pend <= 1'b1;

      ppu_ce <= (pcnt == '0);
      cpu_ce <= (mcnt == '0) && !suppress;
      m2     <= (mcnt >= m2r) && !halted;

      if (rcnt_ppu != '0)
        rcnt_ppu <= rcnt_ppu - CW'(1);
      rst_ppu <= (rcnt_ppu > CW'(1));

      // CPU reset counts PPU strobes seen only once the PPU is out of reset.
      if (rst_ppu) begin
        rcnt_cpu <= CW'(RST_CPU_DLY);
        rst_cpu  <= 1'b1;
      end else if (ppu_ce && rcnt_cpu != '0) begin
        rcnt_cpu <= rcnt_cpu - CW'(1);
        if (rcnt_cpu == CW'(1))
          rst_cpu <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_nes_clkgen.sv
// Directed vector bench for nes_clkgen: table of {inputs, cycles, expected outputs}
// plus a counting sequence over one full PAL joint period.
module tb_nes_clkgen;
  logic clk_ppu8 = 1'b0;
  logic rst, pal_mode, cpu_halt, cpu_step;
  logic ppu_ce, cpu_ce, m2, rst_ppu, rst_cpu, pal_active;

  nes_clkgen dut (
    .clk_ppu8(clk_ppu8), .rst(rst), .pal_mode(pal_mode), .cpu_halt(cpu_halt),
    .cpu_step(cpu_step), .ppu_ce(ppu_ce), .cpu_ce(cpu_ce), .m2(m2),
    .rst_ppu(rst_ppu), .rst_cpu(rst_cpu), .pal_active(pal_active)
  );

  always #5 clk_ppu8 = ~clk_ppu8;

  // exp bit order: {ppu_ce, cpu_ce, m2, rst_ppu, rst_cpu, pal_active}
  typedef struct {
    int         n;
    logic       r, p, h, s;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   nvec = 0;
  int   nmis = 0;

  task automatic add(input int n, input logic r, p, h, s, input logic [5:0] e);
    vec_t v;
    v.n = n; v.r = r; v.p = p; v.h = h; v.s = s; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int got, input int want);
    nvec++;
    if (got != want) begin
      nmis++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  initial begin
    logic [5:0] got;
    int pc, cc, mc;
    rst = 1'b1; pal_mode = 1'b0; cpu_halt = 1'b0; cpu_step = 1'b0;

    // NTSC reset release (edge index k counted from first rst-low edge)
    add( 3, 1, 0, 0, 0, 6'b000110);
    add( 1, 0, 0, 0, 0, 6'b110110);  // k1 first strobes together
    add( 1, 0, 0, 0, 0, 6'b000110);
    add( 7, 0, 0, 0, 0, 6'b100110);  // k9
    add( 5, 0, 0, 0, 0, 6'b000110);  // k14
    add( 1, 0, 0, 0, 0, 6'b000010);  // k15 rst_ppu falls
    add( 2, 0, 0, 0, 0, 6'b101010);  // k17 m2 rises
    add( 7, 0, 0, 0, 0, 6'b001010);  // k24 m2 last high
    add( 1, 0, 0, 0, 0, 6'b110010);  // k25
    add(32, 0, 0, 0, 0, 6'b100010);  // k57 6th ppu_ce with rst_ppu low
    add( 1, 0, 0, 0, 0, 6'b000000);  // k58 rst_cpu falls
    // halt / step
    add(14, 0, 0, 1, 0, 6'b000000);  // k72 m2 forced low
    add( 1, 0, 0, 1, 0, 6'b100000);  // k73 cpu strobe suppressed
    add( 1, 0, 0, 1, 1, 6'b000000);
    add( 2, 0, 0, 1, 0, 6'b000000);
    add( 1, 0, 0, 1, 1, 6'b000000);
    add( 1, 0, 0, 1, 0, 6'b000000);
    add( 1, 0, 0, 1, 1, 6'b000000);
    add(17, 0, 0, 1, 0, 6'b000000);  // k96
    add( 1, 0, 0, 1, 0, 6'b110000);  // k97 single stepped strobe
    add(24, 0, 0, 1, 0, 6'b100000);  // k121 no second strobe
    add(16, 0, 0, 0, 0, 6'b101000);  // k137 m2 back in phase
    add( 8, 0, 0, 0, 0, 6'b110000);  // k145 cpu strobes resume
    // live switch to PAL
    add(10, 0, 1, 0, 0, 6'b000000);  // k155 still NTSC
    add(12, 0, 1, 0, 0, 6'b001000);  // k167
    add( 1, 0, 1, 0, 0, 6'b001001);  // k168 joint wrap
    add( 1, 0, 1, 0, 0, 6'b110001);  // k169
    add(10, 0, 1, 0, 0, 6'b100001);  // k179 ppu period 10
    add(10, 0, 1, 0, 0, 6'b101001);  // k189 m2 at mcnt 20
    add(11, 0, 1, 0, 0, 6'b001001);  // k200
    add( 1, 0, 1, 0, 0, 6'b010001);  // k201 cpu period 32
    add(118, 0, 1, 0, 0, 6'b101001); // k319
    add( 5, 0, 0, 0, 0, 6'b001001);  // k324 pending NTSC request
    add( 5, 0, 1, 0, 0, 6'b110001);  // k329 wrap passed, no change
    // reset mid-operation with halt active
    add( 2, 0, 1, 1, 0, 6'b000001);
    add( 1, 1, 0, 1, 0, 6'b000110);
    add( 1, 0, 0, 1, 0, 6'b110110);
    add(14, 0, 0, 1, 0, 6'b000010);  // k15 full delay again
    add(18, 0, 0, 0, 0, 6'b100010);  // k33 3 strobes counted
    // reset during rst_cpu countdown
    add( 1, 1, 0, 0, 0, 6'b000110);
    add(14, 0, 0, 0, 0, 6'b000110);
    add( 1, 0, 0, 0, 0, 6'b000010);
    add(42, 0, 0, 0, 0, 6'b100010);  // k57 still held
    add( 1, 0, 0, 0, 0, 6'b000000);  // k58
    // PAL reset
    add( 2, 1, 1, 0, 0, 6'b000111);
    add( 1, 0, 1, 0, 0, 6'b110111);
    add(19, 0, 1, 0, 0, 6'b000011);
    add( 1, 0, 1, 0, 0, 6'b101011);  // k21
    add(11, 0, 1, 0, 0, 6'b001011);
    add( 1, 0, 1, 0, 0, 6'b010011);  // k33

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].r; pal_mode = vecs[i].p; cpu_halt = vecs[i].h; cpu_step = vecs[i].s;
      repeat (vecs[i].n) @(posedge clk_ppu8);
      #1;
      got = {ppu_ce, cpu_ce, m2, rst_ppu, rst_cpu, pal_active};
      nvec++;
      if (got !== vecs[i].exp) begin
        nmis++;
        $display("FAIL vec%0d: got %b, want %b", i, got, vecs[i].exp);
      end
    end

    // one full PAL joint period: 16 ppu, 5 cpu, 5x12 m2-high cycles
    cpu_step = 1'b0;
    pc = 0; cc = 0; mc = 0;
    repeat (160) begin
      @(posedge clk_ppu8); #1;
      pc += int'(ppu_ce); cc += int'(cpu_ce); mc += int'(m2);
    end
    check("pal_ppu_count", pc, 16);
    check("pal_cpu_count", cc, 5);
    check("pal_m2_count", mc, 60);
    check("pal_rst_cpu", int'(rst_cpu), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
